// File: rtl/riscv_test_sequencer_if.sv
// Bundle of loader, core-control and result signals around the riscv-tests campaign sequencer.
// The master modport is the sequencer side; the slave modport is the bring-up environment side.
interface riscv_test_sequencer_if #(
    parameter int XLEN      = 32,
    parameter int ID_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 load_req;
    logic                 load_done;
    logic                 core_rst;
    logic                 flush;
    logic [XLEN-1:0]      flush_pc;
    logic [XLEN-1:0]      gp_value;
    logic [ID_WIDTH-1:0]  test_id;
    logic                 busy;
    logic                 result_valid;
    logic                 result_pass;
    logic                 result_timeout;
    logic [XLEN-2:0]      result_fail_num;
    logic [CNT_WIDTH-1:0] pass_count;
    logic [CNT_WIDTH-1:0] fail_count;
    logic                 done;

    modport master (
        input  start, load_done, flush, flush_pc, gp_value,
        output load_req, core_rst, test_id, busy, result_valid, result_pass,
               result_timeout, result_fail_num, pass_count, fail_count, done
    );

    modport slave (
        output start, load_done, flush, flush_pc, gp_value,
        input  load_req, core_rst, test_id, busy, result_valid, result_pass,
               result_timeout, result_fail_num, pass_count, fail_count, done
    );
endinterface

// File: rtl/riscv_test_sequencer.sv
// Campaign controller: load, reset, run, settle and report each riscv-tests binary in turn.
// Optional RUN-state watchdog enabled by defining RISCV_TEST_SEQUENCER_TIMEOUT_EN.
module riscv_test_sequencer #(
    parameter int              NUM_TESTS      = 39,
    parameter int              ID_WIDTH       = 8,
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] END_PC         = 32'h2000_003C,
    parameter int              RST_CYCLES     = 10,
    parameter int              SETTLE_CYCLES  = 10,
    parameter int              TIMEOUT_CYCLES = 100000,
    parameter int              CNT_WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    riscv_test_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RESET  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_REPORT = 3'd5;

    // One shared cycle counter serves RESET, SETTLE and (optionally) RUN.
    localparam int CYC_MAX0 = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CYC_MAX  = (CYC_MAX0 > TIMEOUT_CYCLES) ? CYC_MAX0 : TIMEOUT_CYCLES;
    localparam int CW       = $clog2(CYC_MAX + 1);

    localparam logic [CW-1:0]        RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]        SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [ID_WIDTH-1:0]  LAST_ID     = ID_WIDTH'(NUM_TESTS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    logic [2:0]           state_q,    state_d;
    logic [ID_WIDTH-1:0]  test_id_q,  test_id_d;
    logic [CW-1:0]        cnt_q,      cnt_d;
    logic                 done_q,     done_d;
    logic                 pass_q,     pass_d;
    logic [XLEN-2:0]      fail_num_q, fail_num_d;
    logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
`ifdef RISCV_TEST_SEQUENCER_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic                 timeout_q,  timeout_d;
`endif

    logic end_flush;
    assign end_flush = bus.flush && (bus.flush_pc == END_PC);

    always_comb begin
        state_d    = state_q;
        test_id_d  = test_id_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_num_d = fail_num_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
`ifdef RISCV_TEST_SEQUENCER_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD;
                    test_id_d  = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    done_d     = 1'b0;
                end
            end
            S_LOAD: begin
                if (bus.load_done) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
            end
            S_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                // An end flush on the limit cycle takes priority over the timeout.
                if (end_flush) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
`ifdef RISCV_TEST_SEQUENCER_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = S_REPORT;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b1;
                    fail_num_d = '0;
                    if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d    = S_REPORT;
                    pass_d     = (bus.gp_value == XLEN'(1));
                    fail_num_d = bus.gp_value[XLEN-1:1];
`ifdef RISCV_TEST_SEQUENCER_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    if (bus.gp_value == XLEN'(1)) begin
                        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REPORT: begin
                if (test_id_q == LAST_ID) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_LOAD;
                    test_id_d = test_id_q + ID_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            test_id_q  <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_num_q <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
`ifdef RISCV_TEST_SEQUENCER_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            test_id_q  <= test_id_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_num_q <= fail_num_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
`ifdef RISCV_TEST_SEQUENCER_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    // The core only runs while its program executes and drains; it is held in reset otherwise.
    assign bus.core_rst        = !((state_q == S_RUN) || (state_q == S_SETTLE));
    assign bus.load_req        = (state_q == S_LOAD);
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.result_valid    = (state_q == S_REPORT);
    assign bus.test_id         = test_id_q;
    assign bus.done            = done_q;
    assign bus.result_pass     = pass_q;
    assign bus.result_fail_num = fail_num_q;
    assign bus.pass_count      = pass_cnt_q;
    assign bus.fail_count      = fail_cnt_q;
`ifdef RISCV_TEST_SEQUENCER_TIMEOUT_EN
    assign bus.result_timeout  = timeout_q;
`else
    assign bus.result_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Scoreboard bench for riscv_test_sequencer: directed campaigns with hand-computed results.
// Results are pushed when the end flush is issued and checked by a monitor on RESULT_VALID.
module tb_riscv_test_sequencer;
    localparam int          NUM_TESTS      = 6;
    localparam int          ID_WIDTH       = 8;
    localparam int          XLEN           = 32;
    localparam int          RST_CYCLES     = 10;
    localparam int          SETTLE_CYCLES  = 10;
    localparam int          TIMEOUT_CYCLES = 50;
    localparam int          CNT_WIDTH      = 2;
    localparam logic [31:0] END_PC         = 32'h2000_003C;

    logic clk = 1'b0;
    logic rst = 1'b1;

    riscv_test_sequencer_if #(.XLEN(XLEN), .ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    riscv_test_sequencer #(
        .NUM_TESTS(NUM_TESTS), .ID_WIDTH(ID_WIDTH), .XLEN(XLEN), .END_PC(END_PC),
        .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  id;
        logic        pass;
        logic        tmo;
        logic [30:0] failNum;
        logic [1:0]  passCnt;
        logic [1:0]  failCnt;
    } exp_t;

    exp_t sbQ[$];
    exp_t monExp;
    int   compared   = 0;
    int   mismatched = 0;
    int   expPass    = 0;
    int   expFail    = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model of one result: pass iff gp==1, failing case number gp>>1, saturating totals.
    task automatic pushExpect(input int id, input logic [31:0] gp, input bit tmo);
        exp_t e;
        e.id  = 8'(id);
        e.tmo = tmo;
        if (tmo) begin
            e.pass    = 1'b0;
            e.failNum = '0;
            if (expFail < 3) expFail++;
        end else begin
            e.pass    = (gp == 32'd1);
            e.failNum = gp[31:1];
            if (gp == 32'd1) begin
                if (expPass < 3) expPass++;
            end else begin
                if (expFail < 3) expFail++;
            end
        end
        e.passCnt = 2'(expPass);
        e.failCnt = 2'(expFail);
        sbQ.push_back(e);
    endtask

    // Monitor: every RESULT_VALID strobe consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && bus.result_valid) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got a result for test %0d, expected none", bus.test_id);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("result_test_id", 64'(bus.test_id), 64'(monExp.id));
                checkOutput("result_pass", 64'(bus.result_pass), 64'(monExp.pass));
                checkOutput("result_timeout", 64'(bus.result_timeout), 64'(monExp.tmo));
                checkOutput("result_fail_num", 64'(bus.result_fail_num), 64'(monExp.failNum));
                checkOutput("pass_count", 64'(bus.pass_count), 64'(monExp.passCnt));
                checkOutput("fail_count", 64'(bus.fail_count), 64'(monExp.failCnt));
            end
        end
    end

    task automatic pulseStart();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits for LOAD, holds LOAD_DONE low loadDelay cycles, then measures the core reset pulse.
    task automatic doLoad(input int loadDelay, input int expId);
        bit ok   = 1'b0;
        bit good = 1'b1;
        int k;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.load_req) ok = 1'b1;
            else @(negedge clk);
        end
        checkOutput("load_req_seen", 64'(ok), 64'd1);
        checkOutput("test_id", 64'(bus.test_id), 64'(expId));
        for (int i = 0; i < loadDelay; i++) begin
            if (!(bus.load_req && bus.core_rst)) good = 1'b0;
            @(negedge clk);
        end
        checkOutput("load_hold", {61'd0, good, bus.load_req, bus.core_rst}, 64'd7);
        bus.load_done = 1'b1;
        @(negedge clk);
        bus.load_done = 1'b0;
        checkOutput("load_req_drop", 64'(bus.load_req), 64'd0);
        k = 0;
        while (bus.core_rst && k < 100) begin
            k++;
            @(negedge clk);
        end
        checkOutput("rst_cycles", 64'(k), 64'(RST_CYCLES));
    endtask

    // Called on the first RUN cycle; gp is wrong until mid-SETTLE so early sampling is caught.
    task automatic applyStimulus(input logic [31:0] gp, input bit badFlush, input int expId);
        int k;
        if (badFlush) begin
            bus.flush_pc = 32'h2000_0040;
            bus.flush    = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
            repeat (19) @(negedge clk);
            checkOutput("bad_flush_ignored", {62'd0, bus.core_rst, bus.result_valid}, 64'd0);
        end
        bus.gp_value = ~gp;
        bus.flush_pc = END_PC;
        bus.flush    = 1'b1;
        pushExpect(expId, gp, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            bus.flush = 1'b0;
            k++;
            if (k == 5) bus.gp_value = gp;
        end while (!bus.result_valid && k < 100);
        checkOutput("settle_latency", 64'(k), 64'(SETTLE_CYCLES + 1));
    endtask

    initial begin
        logic [31:0] gpTab [NUM_TESTS];
        int k;
        gpTab = '{32'h1, 32'h7, 32'h1, 32'h1, 32'h64, 32'h1};
        bus.start     = 1'b0;
        bus.load_done = 1'b0;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        bus.gp_value  = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_core_rst", 64'(bus.core_rst), 64'd1);
        checkOutput("reset_outputs",
                    {55'd0, bus.busy, bus.load_req, bus.done, bus.result_valid,
                     bus.result_pass, bus.pass_count, bus.fail_count}, 64'd0);
        checkOutput("reset_test_id", 64'(bus.test_id), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] campaign A: six tests, mixed results, saturating pass count");
        pulseStart();
        checkOutput("busy_after_start", 64'(bus.busy), 64'd1);
        for (int t = 0; t < NUM_TESTS; t++) begin
            if (t == 2) pulseStart();
            doLoad((t == 0) ? 30 : 0, t);
            applyStimulus(gpTab[t], (t == 1), t);
        end
        @(negedge clk);
        checkOutput("done_busy_end", {62'd0, bus.done, bus.busy}, 64'd2);
        checkOutput("result_hold", {62'd0, bus.result_valid, bus.result_pass}, 64'd1);
        checkOutput("totals_end", {60'd0, bus.pass_count, bus.fail_count}, 64'hE);
        repeat (3) @(negedge clk);
        checkOutput("done_held", 64'(bus.done), 64'd1);

        $display("[TB] campaign B: reset during test 5");
        pulseStart();
        expPass = 0;
        expFail = 0;
        checkOutput("restart_clears", {59'd0, bus.done, bus.pass_count, bus.fail_count}, 64'd0);
        for (int t = 0; t < 5; t++) begin
            doLoad(0, t);
            applyStimulus(32'h1, 1'b0, t);
        end
        doLoad(0, 5);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrun_reset_core_rst", 64'(bus.core_rst), 64'd1);
        checkOutput("midrun_reset_state",
                    {58'd0, bus.busy, bus.load_req, bus.pass_count, bus.fail_count}, 64'd0);
        checkOutput("midrun_reset_test_id", 64'(bus.test_id), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        expPass = 0;
        expFail = 0;
        @(negedge clk);

        $display("[TB] campaign C: restart from test 0");
        pulseStart();
        checkOutput("restart_load", {62'd0, bus.busy, bus.load_req}, 64'd3);
        doLoad(0, 0);
`ifdef RISCV_TEST_SEQUENCER_TIMEOUT_EN
        pushExpect(0, 32'h0, 1'b1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.result_valid && k < 200);
        checkOutput("timeout_latency", 64'(k), 64'(TIMEOUT_CYCLES));
        doLoad(0, 1);
`else
        applyStimulus(32'h3, 1'b0, 0);
        k = 0;
`endif
        @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3_000_000;
        compared++;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
